spram_bus_bridge: RTL and testbench



---
 rtl/spram_bus_bridge.sv | 167 ++++++++++++++++
 tb/tb_spram_bus_bridge.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_bus_bridge.sv
// Valid/ready front end for a lo/hi pair of SB_SPRAM256KA (64 KiB, 32-bit words),
// with a power-up delay, idle auto-standby and requested sleep.
module spram_bus_bridge #(
   parameter int POWERUP_CYCLES = 4,
   parameter int IDLE_CYCLES    = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        bus_valid,
   output logic        bus_ready,
   input  logic [13:0] bus_addr,
   input  logic [3:0]  bus_wstrb,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   input  logic        sleep_req,
   output logic [13:0] spram_address,
   output logic [15:0] spram_datain_lo,
   output logic [15:0] spram_datain_hi,
   output logic [3:0]  spram_maskwren_lo,
   output logic [3:0]  spram_maskwren_hi,
   output logic        spram_wren,
   output logic        spram_cs,
   output logic        spram_standby,
   output logic        spram_sleep,
   output logic        spram_poweroff,
   input  logic [15:0] spram_dataout_lo,
   input  logic [15:0] spram_dataout_hi
);

   localparam logic [2:0] ST_OFF     = 3'd0;
   localparam logic [2:0] ST_POWERUP = 3'd1;
   localparam logic [2:0] ST_READY   = 3'd2;
   localparam logic [2:0] ST_ACK     = 3'd3;
   localparam logic [2:0] ST_STANDBY = 3'd4;
   localparam logic [2:0] ST_WAKE    = 3'd5;
   localparam logic [2:0] ST_SLEEP   = 3'd6;

   localparam int              PU_W      = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
   localparam logic [PU_W-1:0] PU_LAST   = PU_W'(POWERUP_CYCLES - 1);
   localparam logic [PU_W-1:0] PU_ONE    = PU_W'(1);
   localparam int              IDLE_W    = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYCLES > 0) ? (IDLE_CYCLES - 1) : 0);
   localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
   localparam bit              IDLE_EN   = (IDLE_CYCLES != 0);

   logic [2:0]        r_state;
   logic [2:0]        w_next_state;
   logic [PU_W-1:0]   r_pu_cnt;
   logic [PU_W-1:0]   w_pu_cnt_next;
   logic [IDLE_W-1:0] r_idle_cnt;
   logic [IDLE_W-1:0] w_idle_cnt_next;
   logic              r_rd;
   logic              r_bus_ready;
   logic              r_standby;
   logic              r_sleep;
   logic              r_poweroff;
   logic              w_issue;
   logic              w_write;

   assign w_issue = (r_state == ST_READY) && bus_valid;
   assign w_write = |bus_wstrb;

   // Access signals are combinational so the SPRAM samples the request on the issue edge.
   assign spram_address     = bus_addr;
   assign spram_datain_lo   = bus_wdata[15:0];
   assign spram_datain_hi   = bus_wdata[31:16];
   assign spram_cs          = w_issue;
   assign spram_wren        = w_issue && w_write;
   assign spram_maskwren_lo = w_issue ? {bus_wstrb[1], bus_wstrb[1], bus_wstrb[0], bus_wstrb[0]} : 4'b0000;
   assign spram_maskwren_hi = w_issue ? {bus_wstrb[3], bus_wstrb[3], bus_wstrb[2], bus_wstrb[2]} : 4'b0000;

   assign bus_ready      = r_bus_ready;
   assign bus_rdata      = (r_bus_ready && r_rd) ? {spram_dataout_hi, spram_dataout_lo} : 32'h0000_0000;
   assign spram_standby  = r_standby;
   assign spram_sleep    = r_sleep;
   assign spram_poweroff = r_poweroff;

   // Next-state and counter update logic.
   always_comb begin
      w_next_state    = r_state;
      w_pu_cnt_next   = r_pu_cnt;
      w_idle_cnt_next = r_idle_cnt;
      case (r_state)
         ST_OFF: begin
            w_next_state  = ST_POWERUP;
            w_pu_cnt_next = {PU_W{1'b0}};
         end
         ST_POWERUP: begin
            if (r_pu_cnt == PU_LAST) begin
               w_next_state  = ST_READY;
               w_pu_cnt_next = {PU_W{1'b0}};
            end else begin
               w_pu_cnt_next = r_pu_cnt + PU_ONE;
            end
         end
         ST_READY: begin
            if (bus_valid) begin
               w_next_state    = ST_ACK;
               w_idle_cnt_next = {IDLE_W{1'b0}};
            end else if (sleep_req) begin
               w_next_state    = ST_SLEEP;
               w_idle_cnt_next = {IDLE_W{1'b0}};
            end else if (IDLE_EN && (r_idle_cnt == IDLE_LAST)) begin
               w_next_state    = ST_STANDBY;
               w_idle_cnt_next = {IDLE_W{1'b0}};
            end else if (IDLE_EN) begin
               w_idle_cnt_next = r_idle_cnt + IDLE_ONE;
            end else begin
               w_idle_cnt_next = {IDLE_W{1'b0}};
            end
         end
         ST_ACK: begin
            w_next_state = ST_READY;
         end
         ST_STANDBY: begin
            if (bus_valid) begin
               w_next_state = ST_WAKE;
            end else if (sleep_req) begin
               w_next_state = ST_SLEEP;
            end else begin
               w_next_state = ST_STANDBY;
            end
         end
         ST_WAKE: begin
            w_next_state = ST_READY;
         end
         ST_SLEEP: begin
            if (!sleep_req) begin
               w_next_state  = ST_POWERUP;
               w_pu_cnt_next = {PU_W{1'b0}};
            end else begin
               w_next_state = ST_SLEEP;
            end
         end
         default: begin
            // An illegal encoding re-runs the full power-up sequence.
            w_next_state    = ST_POWERUP;
            w_pu_cnt_next   = {PU_W{1'b0}};
            w_idle_cnt_next = {IDLE_W{1'b0}};
         end
      endcase
   end

   // State, counters and status outputs, registered from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_OFF;
         r_pu_cnt    <= {PU_W{1'b0}};
         r_idle_cnt  <= {IDLE_W{1'b0}};
         r_rd        <= 1'b0;
         r_bus_ready <= 1'b0;
         r_standby   <= 1'b0;
         r_sleep     <= 1'b0;
         r_poweroff  <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_pu_cnt    <= w_pu_cnt_next;
         r_idle_cnt  <= w_idle_cnt_next;
         r_rd        <= w_issue ? ~w_write : r_rd;
         r_bus_ready <= (w_next_state == ST_ACK);
         r_standby   <= (w_next_state == ST_STANDBY) || (w_next_state == ST_SLEEP);
         r_sleep     <= (w_next_state == ST_SLEEP);
         r_poweroff  <= (w_next_state != ST_OFF);
      end
   end

endmodule

// File: tb/tb_spram_bus_bridge.sv
// Self-checking bench for spram_bus_bridge: table-driven vectors, randomized traffic
// against a byte-level memory reference, and hand sequences for power-state corners.
module tb_spram_bus_bridge;

   logic        clk;
   logic        reset_n;
   logic        bus_valid;
   logic        bus_ready;
   logic [13:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        sleep_req;
   logic [13:0] spram_address;
   logic [15:0] spram_datain_lo;
   logic [15:0] spram_datain_hi;
   logic [3:0]  spram_maskwren_lo;
   logic [3:0]  spram_maskwren_hi;
   logic        spram_wren;
   logic        spram_cs;
   logic        spram_standby;
   logic        spram_sleep;
   logic        spram_poweroff;
   logic [15:0] spram_dataout_lo;
   logic [15:0] spram_dataout_hi;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] mem_lo  [0:16383];
   logic [15:0] mem_hi  [0:16383];
   logic [31:0] ref_mem [0:16383];

   typedef struct {
      logic [13:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [3:0]  exp_mlo;
      logic [3:0]  exp_mhi;
   } vec_t;

   vec_t vecs [12];

   spram_bus_bridge #(.POWERUP_CYCLES(4), .IDLE_CYCLES(8)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .bus_valid         (bus_valid),
      .bus_ready         (bus_ready),
      .bus_addr          (bus_addr),
      .bus_wstrb         (bus_wstrb),
      .bus_wdata         (bus_wdata),
      .bus_rdata         (bus_rdata),
      .sleep_req         (sleep_req),
      .spram_address     (spram_address),
      .spram_datain_lo   (spram_datain_lo),
      .spram_datain_hi   (spram_datain_hi),
      .spram_maskwren_lo (spram_maskwren_lo),
      .spram_maskwren_hi (spram_maskwren_hi),
      .spram_wren        (spram_wren),
      .spram_cs          (spram_cs),
      .spram_standby     (spram_standby),
      .spram_sleep       (spram_sleep),
      .spram_poweroff    (spram_poweroff),
      .spram_dataout_lo  (spram_dataout_lo),
      .spram_dataout_hi  (spram_dataout_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] nib_merge(input logic [15:0] old, input logic [15:0] d,
                                             input logic [3:0] m);
      logic [15:0] r;
      r = old;
      for (int n = 0; n < 4; n++) if (m[n]) r[4*n +: 4] = d[4*n +: 4];
      return r;
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Behavioural model of the two SPRAM instances.
   always @(posedge clk) begin
      if (spram_cs) begin
         if (spram_wren) begin
            mem_lo[spram_address] <= nib_merge(mem_lo[spram_address], spram_datain_lo, spram_maskwren_lo);
            mem_hi[spram_address] <= nib_merge(mem_hi[spram_address], spram_datain_hi, spram_maskwren_hi);
         end else begin
            spram_dataout_lo <= mem_lo[spram_address];
            spram_dataout_hi <= mem_hi[spram_address];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at negedge+1; returns at negedge+1 of the ACK cycle.
   task automatic do_access(input logic [13:0] a, input logic [3:0] s, input logic [31:0] d,
                            input int exp_issue, input logic [31:0] exp_rd,
                            input logic [3:0] exp_mlo, input logic [3:0] exp_mhi);
      int issue_at;
      int ready_at;
      issue_at  = -1;
      ready_at  = -1;
      bus_valid = 1'b1;
      bus_addr  = a;
      bus_wstrb = s;
      bus_wdata = d;
      #1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         if (spram_cs && issue_at < 0) begin
            issue_at = k;
            chk("mask_lo", 32'(spram_maskwren_lo), 32'(exp_mlo));
            chk("mask_hi", 32'(spram_maskwren_hi), 32'(exp_mhi));
            chk("wren", 32'(spram_wren), 32'(|s));
            chk("address", 32'(spram_address), 32'(a));
         end
         if (bus_ready && issue_at >= 0) begin
            ready_at = k;
            chk("rdata", bus_rdata, exp_rd);
            break;
         end else if (!bus_ready) begin
            chk("rdata_idle", bus_rdata, 32'h0);
         end
      end
      bus_valid = 1'b0;
      bus_wstrb = 4'h0;
      chk("issue_cycle", 32'(issue_at), 32'(exp_issue));
      chk("ready_latency", 32'(ready_at - issue_at), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first;
      logic [13:0] a;
      logic [3:0]  s;
      logic [31:0] d;
      int gap;

      vecs[0]  = '{14'h0010, 4'hF, 32'hDEADBEEF, 32'h00000000, 4'hF, 4'hF};
      vecs[1]  = '{14'h0010, 4'h0, 32'h00000000, 32'hDEADBEEF, 4'h0, 4'h0};
      vecs[2]  = '{14'h0020, 4'hF, 32'hAAAAAAAA, 32'h00000000, 4'hF, 4'hF};
      vecs[3]  = '{14'h0020, 4'h5, 32'h11223344, 32'h00000000, 4'h3, 4'h3};
      vecs[4]  = '{14'h0020, 4'h0, 32'h00000000, 32'hAA22AA44, 4'h0, 4'h0};
      vecs[5]  = '{14'h0020, 4'hA, 32'h55667788, 32'h00000000, 4'hC, 4'hC};
      vecs[6]  = '{14'h0020, 4'h0, 32'h00000000, 32'h55227744, 4'h0, 4'h0};
      vecs[7]  = '{14'h3FFF, 4'hF, 32'h12345678, 32'h00000000, 4'hF, 4'hF};
      vecs[8]  = '{14'h3FFF, 4'h6, 32'hCAFEF00D, 32'h00000000, 4'hC, 4'h3};
      vecs[9]  = '{14'h3FFF, 4'h0, 32'h00000000, 32'h12FEF078, 4'h0, 4'h0};
      vecs[10] = '{14'h0020, 4'h9, 32'hA1B2C3D4, 32'h00000000, 4'h3, 4'hC};
      vecs[11] = '{14'h0020, 4'h0, 32'h00000000, 32'hA12277D4, 4'h0, 4'h0};

      reset_n   = 1'b0;
      sleep_req = 1'b0;
      bus_valid = 1'b1;
      bus_addr  = 14'h0010;
      bus_wstrb = 4'h0;
      bus_wdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_poweroff", 32'(spram_poweroff), 32'd0);
      chk("rst_cs", 32'(spram_cs), 32'd0);
      chk("rst_ready", 32'(bus_ready), 32'd0);
      chk("rst_rdata", bus_rdata, 32'h0);
      chk("rst_standby_sleep", 32'({spram_standby, spram_sleep}), 32'd0);
      chk("rst_masks_wren", 32'({spram_maskwren_hi, spram_maskwren_lo, spram_wren}), 32'd0);

      // Power-up with a read request held from release.
      reset_n = 1'b1;
      first   = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         #1;
         if (c == 1) begin
            chk("pu_poweroff_c1", 32'(spram_poweroff), 32'd1);
            chk("pu_ready_c1", 32'(bus_ready), 32'd0);
         end
         if (bus_ready) begin
            first = c;
            break;
         end
      end
      bus_valid = 1'b0;
      chk("pu_first_ready_cycle", 32'(first), 32'd6);

      foreach (vecs[i]) begin
         do_access(vecs[i].addr, vecs[i].strb, vecs[i].wdata, 1, vecs[i].exp_rd,
                   vecs[i].exp_mlo, vecs[i].exp_mhi);
         ref_mem[vecs[i].addr] = byte_merge(ref_mem[vecs[i].addr], vecs[i].wdata, vecs[i].strb);
      end

      for (int i = 0; i < 64; i++) begin
         d = $urandom;
         do_access(14'(i), 4'hF, d, 1, 32'h0, 4'hF, 4'hF);
         ref_mem[i] = d;
      end

      for (int i = 0; i < 150; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            @(negedge clk);
            #1;
         end
         a = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 63));
         s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         d = $urandom;
         do_access(a, s, d, (gap == 0) ? 1 : 0, (s == 4'h0) ? ref_mem[a] : 32'h0,
                   {s[1], s[1], s[0], s[0]}, {s[3], s[3], s[2], s[2]});
         ref_mem[a] = byte_merge(ref_mem[a], d, s);
      end

      // Auto-standby after 8 idle READY cycles, then wake on a read.
      first = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         #1;
         if (spram_standby) begin
            first = n;
            break;
         end
      end
      chk("standby_entry_sample", 32'(first), 32'd9);
      do_access(14'h3FFF, 4'h0, 32'h0, 2, ref_mem[14'h3FFF], 4'h0, 4'h0);
      chk("standby_cleared", 32'(spram_standby), 32'd0);

      // Sleep on request; requests ignored until power-up completes again.
      @(negedge clk);
      #1;
      sleep_req = 1'b1;
      @(negedge clk);
      #1;
      chk("sleep_pins", 32'({spram_sleep, spram_standby, spram_poweroff}), 32'b111);
      bus_valid = 1'b1;
      bus_addr  = 14'h0020;
      bus_wstrb = 4'h0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         chk("sleep_no_ready", 32'(bus_ready), 32'd0);
         chk("sleep_no_cs", 32'(spram_cs), 32'd0);
      end
      sleep_req = 1'b0;
      first     = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         #1;
         if (c == 1) chk("wake_pins", 32'({spram_sleep, spram_standby, spram_poweroff}), 32'b001);
         if (bus_ready) begin
            first = c;
            chk("post_sleep_rdata", bus_rdata, ref_mem[14'h0020]);
            break;
         end
      end
      bus_valid = 1'b0;
      chk("post_sleep_ready_cycle", 32'(first), 32'd6);

      // Reset asserted while in ACK.
      chk("pre_reset_in_ack", 32'(bus_ready), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_ack_ready", 32'(bus_ready), 32'd0);
      chk("rst_ack_cs", 32'(spram_cs), 32'd0);
      chk("rst_ack_poweroff", 32'(spram_poweroff), 32'd0);
      chk("rst_ack_rdata", bus_rdata, 32'h0);
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
